// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension execute unit: shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up in a final cycle, start/done handshake.
module mul_div_unit #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic              neg_q_q, neg_r_q, special_q;
    logic [XLEN-1:0]   a_mag_q, b_mag_q, spec_res_q, result_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [CW-1:0]     cnt_q;

    logic              sgn_a_in, sgn_b_in, div_zero_in, ovf_in, special_in;
    logic              accept, early;
    logic [XLEN-1:0]   a_mag_in, b_mag_in, spec_res_in;
    logic [XLEN:0]     sum;
    logic [XLEN+1:0]   trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_f, rem_f, fix_res;

    // Operand decode on the request inputs, used only on the accepting edge
    always_comb begin
        sgn_a_in    = ((funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                       (funct3_i[2] && !funct3_i[0])) && rs1_i[XLEN-1];
        sgn_b_in    = ((funct3_i == 3'b001) || (funct3_i[2] && !funct3_i[0])) &&
                      rs2_i[XLEN-1];
        a_mag_in    = sgn_a_in ? -rs1_i : rs1_i;
        b_mag_in    = sgn_b_in ? -rs2_i : rs2_i;
        div_zero_in = funct3_i[2] && (rs2_i == '0);
        ovf_in      = funct3_i[2] && !funct3_i[0] && (rs1_i == MIN_VAL) && (rs2_i == '1);
        special_in  = div_zero_in || ovf_in;
        if (div_zero_in)
            spec_res_in = funct3_i[1] ? rs1_i : '1;
        else
            spec_res_in = funct3_i[1] ? '0 : rs1_i;
        accept = ready_o && start_i && !flush_i;
        early  = EARLY_OUT && special_in;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_o = (state_q == IDLE) || (state_q == DONE);
        busy_o  = (state_q == CALC) || (state_q == FIX);
        done_o  = (state_q == DONE);
        case (state_q)
            IDLE:    if (accept) state_d = early ? DONE : CALC;
            CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = accept ? (early ? DONE : CALC) : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    // One iteration of each datapath; rem_q[XLEN] stays 0 so {rem_q, bit} is the shifted remainder
    always_comb begin
        sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_mag_q};
        trial = {rem_q, quo_q[XLEN-1]} - {2'b00, b_mag_q};
        prod  = neg_q_q ? -acc_q : acc_q;
        quo_f = neg_q_q ? -quo_q : quo_q;
        rem_f = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        if (special_q)
            fix_res = spec_res_q;
        else if (op_q[2])
            fix_res = op_q[1] ? rem_f : quo_f;
        else if (op_q[1:0] == 2'b00)
            fix_res = prod[XLEN-1:0];
        else
            fix_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q       <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            special_q  <= 1'b0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            spec_res_q <= '0;
            result_q   <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
        end else if (accept) begin
            op_q       <= funct3_i;
            neg_q_q    <= sgn_a_in ^ sgn_b_in;
            neg_r_q    <= sgn_a_in;
            special_q  <= special_in;
            a_mag_q    <= a_mag_in;
            b_mag_q    <= b_mag_in;
            spec_res_q <= spec_res_in;
            acc_q      <= {{XLEN{1'b0}}, b_mag_in};
            rem_q      <= '0;
            quo_q      <= a_mag_in;
            cnt_q      <= '0;
            if (early)
                result_q <= spec_res_in;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            if (op_q[2]) begin
                quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN+1]};
                rem_q <= trial[XLEN+1] ? {rem_q[XLEN-1:0], quo_q[XLEN-1]} : trial[XLEN:0];
            end else if (acc_q[0]) begin
                acc_q <= {sum, acc_q[XLEN-1:1]};
            end else begin
                acc_q <= {1'b0, acc_q[2*XLEN-1:1]};
            end
        end else if ((state_q == FIX) && !flush_i) begin
            result_q <= fix_res;
        end
    end

    assign result_o = result_q;

endmodule
